icache_ctrl: RTL

Direct-mapped instruction cache and fetch sequencer between the instruction fetcher and the memory controller's instruction port. Hits return in one cycle without touching memory. Misses issue one 4-byte fetch to the memory controller, fill the line and forward the word. On a branch mispredict, any fetch still in flight is drained and its result is not delivered.

---
 rtl/icache_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/icache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : icache_ctrl
// Description : Direct-mapped instruction cache with fetch sequencer. Hits
//               answer in one cycle; misses fetch one word from the memory
//               controller, fill the line and forward the word. A mispredict
//               drains an in-flight fetch without delivering its result.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_ctrl #(
    parameter int INDEX_WIDTH = 8,
    parameter int TAG_WIDTH   = 30 - INDEX_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        enable_from_if,
    input  logic [31:0] addr_from_if,
    output logic        enable_to_if,
    output logic [31:0] ins_to_if,
    output logic        enable_to_memctrl,
    output logic [31:0] addr_to_memctrl,
    input  logic        ok_from_memctrl,
    input  logic [31:0] ins_from_memctrl,
    input  logic        mispredict
);

    localparam int c_LINES = 1 << INDEX_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t                 state_q;
    logic [c_LINES-1:0]     valid_q;
    logic [TAG_WIDTH-1:0]   tag_q  [c_LINES];
    logic [31:0]            data_q [c_LINES];

    logic                   enable_to_if_q;
    logic [31:0]            ins_to_if_q;
    logic                   enable_to_memctrl_q;
    logic [31:0]            addr_to_memctrl_q;

    logic [INDEX_WIDTH-1:0] w_req_idx;
    logic [TAG_WIDTH-1:0]   w_req_tag;
    logic                   w_hit;
    logic [INDEX_WIDTH-1:0] w_fill_idx;
    logic [TAG_WIDTH-1:0]   w_fill_tag;
    logic                   w_fill;
    logic                   w_unused_addr_bits;

    // Lookup of the incoming request; the miss address register doubles as
    // the latched fill address for the outstanding fetch.
    assign w_req_idx          = addr_from_if[2 +: INDEX_WIDTH];
    assign w_req_tag          = addr_from_if[2 + INDEX_WIDTH +: TAG_WIDTH];
    assign w_hit              = valid_q[w_req_idx] && (tag_q[w_req_idx] == w_req_tag);
    assign w_fill_idx         = addr_to_memctrl_q[2 +: INDEX_WIDTH];
    assign w_fill_tag         = addr_to_memctrl_q[2 + INDEX_WIDTH +: TAG_WIDTH];
    assign w_fill             = !rst && rdy && ok_from_memctrl && (state_q != ST_IDLE);
    assign w_unused_addr_bits = ^addr_from_if[1:0];

    assign enable_to_if       = enable_to_if_q;
    assign ins_to_if          = ins_to_if_q;
    assign enable_to_memctrl  = enable_to_memctrl_q;
    assign addr_to_memctrl    = addr_to_memctrl_q;

    // Tag/data storage: written on every returning fetch, discarded or not,
    // since the returned word is always correct for the latched address.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            tag_q[w_fill_idx]  <= w_fill_tag;
            data_q[w_fill_idx] <= ins_from_memctrl;
        end
    end

    // Fetch sequencer with registered outputs and per-line valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q             <= ST_IDLE;
            valid_q             <= '0;
            enable_to_if_q      <= 1'b0;
            ins_to_if_q         <= 32'd0;
            enable_to_memctrl_q <= 1'b0;
            addr_to_memctrl_q   <= 32'd0;
        end else if (rdy) begin
            enable_to_if_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A request colliding with a mispredict is dropped outright.
                    if (enable_from_if && !mispredict) begin
                        if (w_hit) begin
                            enable_to_if_q <= 1'b1;
                            ins_to_if_q    <= data_q[w_req_idx];
                        end else begin
                            enable_to_memctrl_q <= 1'b1;
                            addr_to_memctrl_q   <= {addr_from_if[31:2], 2'b00};
                            state_q             <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (ok_from_memctrl) begin
                        valid_q[w_fill_idx] <= 1'b1;
                        enable_to_memctrl_q <= 1'b0;
                        state_q             <= ST_IDLE;
                        if (!mispredict) begin
                            enable_to_if_q <= 1'b1;
                            ins_to_if_q    <= ins_from_memctrl;
                        end
                    end else if (mispredict) begin
                        // Memctrl cannot abort: keep requesting, drop the result.
                        state_q <= ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (ok_from_memctrl) begin
                        valid_q[w_fill_idx] <= 1'b1;
                        enable_to_memctrl_q <= 1'b0;
                        state_q             <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
